// File: rtl/a5_keystream_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a5_keystream_sequencer_if                                                |
// | Config, A5/1 core control and keystream FIFO write-port signal bundle.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface a5_keystream_sequencer_if;
  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        busy;
  logic        done;
  logic        core_clear;
  logic        core_step;
  logic        core_force;
  logic        core_bit;
  logic        core_ks;
  logic        buf_full;
  logic        buf_wr_en;
  logic [31:0] buf_wr_data;

  modport master (
    input  start, key, frame, core_ks, buf_full,
    output busy, done, core_clear, core_step, core_force, core_bit,
           buf_wr_en, buf_wr_data
  );

  modport slave (
    output start, key, frame, core_ks, buf_full,
    input  busy, done, core_clear, core_step, core_force, core_bit,
           buf_wr_en, buf_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/a5_keystream_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | a5_keystream_sequencer                                                   |
// | Drives an A5/1 core through clear/key/frame/mix and packs keystream into |
// | 32-bit FIFO words. Option macro: A5_SEQ_CONTINUOUS_EN (auto next frame). |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module a5_keystream_sequencer #(
  parameter int NUM_WORDS  = 8,
  parameter int MIX_CYCLES = 100
) (
  input  wire logic                clk,
  input  wire logic                reset,
  a5_keystream_sequencer_if.master bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLEAR = 3'd1;
  localparam logic [2:0] c_KEY   = 3'd2;
  localparam logic [2:0] c_FRAME = 3'd3;
  localparam logic [2:0] c_MIX   = 3'd4;
  localparam logic [2:0] c_GEN   = 3'd5;
  localparam logic [2:0] c_PUSH  = 3'd6;
  localparam logic [2:0] c_DONE  = 3'd7;

  localparam logic [6:0] c_MIX_LAST  = 7'(MIX_CYCLES - 1);
  localparam logic [7:0] c_WORD_LAST = 8'(NUM_WORDS - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [6:0]  r_bit_cnt;
  logic [7:0]  r_word_cnt;
  logic [31:0] r_shift;
  logic [63:0] r_key;
  logic [21:0] r_frame;
  logic        w_step;
  logic        w_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_state_next = c_CLEAR;
      c_CLEAR: w_state_next = c_KEY;
      c_KEY:   if (r_bit_cnt == 7'd63) w_state_next = c_FRAME;
      c_FRAME: if (r_bit_cnt == 7'd21) w_state_next = c_MIX;
      c_MIX:   if (r_bit_cnt == c_MIX_LAST) w_state_next = c_GEN;
      c_GEN:   if (r_bit_cnt == 7'd31) w_state_next = c_PUSH;
      c_PUSH: begin
        if (!bus.buf_full) begin
          w_state_next = (r_word_cnt == c_WORD_LAST) ? c_DONE : c_GEN;
        end
      end
`ifdef A5_SEQ_CONTINUOUS_EN
      c_DONE:  w_state_next = bus.start ? c_CLEAR : c_IDLE;
`else
      c_DONE:  w_state_next = c_IDLE;
`endif
      default: w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_step          = (r_state == c_KEY) || (r_state == c_FRAME) ||
                      (r_state == c_MIX) || (r_state == c_GEN);
    w_write         = (r_state == c_PUSH) && !bus.buf_full;
    bus.busy        = (r_state != c_IDLE);
    bus.done        = (r_state == c_DONE);
    bus.core_clear  = (r_state == c_CLEAR);
    bus.core_step   = w_step;
    bus.core_force  = (r_state == c_KEY) || (r_state == c_FRAME);
    bus.core_bit    = 1'b0;
    if (r_state == c_KEY) begin
      bus.core_bit = r_key[r_bit_cnt[5:0]];
    end else if (r_state == c_FRAME) begin
      bus.core_bit = r_frame[r_bit_cnt[4:0]];
    end
    bus.buf_wr_en   = w_write;
    bus.buf_wr_data = (r_state == c_PUSH) ? r_shift : 32'd0;
  end

  // The bit counter restarts on every state change so each phase counts from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= 7'd0;
      r_word_cnt <= 8'd0;
      r_shift    <= 32'd0;
      r_key      <= 64'd0;
      r_frame    <= 22'd0;
    end else begin
      if (w_state_next != r_state) begin
        r_bit_cnt <= 7'd0;
      end else if (w_step) begin
        r_bit_cnt <= r_bit_cnt + 7'd1;
      end

      if (w_state_next == c_CLEAR) begin
        r_word_cnt <= 8'd0;
      end else if (w_write) begin
        r_word_cnt <= r_word_cnt + 8'd1;
      end

      if (r_state == c_GEN) begin
        r_shift <= {r_shift[30:0], bus.core_ks};
      end

      if (r_state == c_IDLE && bus.start) begin
        r_key   <= bus.key;
        r_frame <= bus.frame;
      end
`ifdef A5_SEQ_CONTINUOUS_EN
      if (r_state == c_DONE && bus.start) begin
        r_frame <= r_frame + 22'd1;
      end
`endif
    end
  end

endmodule
`default_nettype wire
